// File: rtl/axi4_slave_ram_if.sv
// AXI4 write/read channel bundle for axi4_slave_ram.
// The master modport drives requests and write data; the slave modport
// drives the ready signals, the B response and the R channel.
interface axi4_slave_ram_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ID_W-1:0]     S_AXI_AWID;
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [7:0]          S_AXI_AWLEN;
    logic [2:0]          S_AXI_AWSIZE;
    logic [1:0]          S_AXI_AWBURST;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WLAST;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [ID_W-1:0]     S_AXI_BID;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ID_W-1:0]     S_AXI_ARID;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [7:0]          S_AXI_ARLEN;
    logic [2:0]          S_AXI_ARSIZE;
    logic [1:0]          S_AXI_ARBURST;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [ID_W-1:0]     S_AXI_RID;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RLAST;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
        output S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE,
        output S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
        input  S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
        input  S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE,
        input  S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
        output S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi4_slave_ram.sv
// AXI4 slave backed by a dual-port RAM; one outstanding burst per direction.
// Ports: S_AXI_ACLK, S_AXI_ARESET (async, active-high), s_axi (slave modport).
// Macro AXI_SLV_DECERR_EN: out-of-range beats give DECERR instead of wrapping.
module axi4_slave_ram #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_BASE_ADDR = '0,
    parameter int C_S_RAM_DEPTH_LOG2 = 10
) (
    input logic             S_AXI_ACLK,
    input logic             S_AXI_ARESET,
    axi4_slave_ram_if.slave s_axi
);
    localparam int NB    = C_S_AXI_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(NB);
    localparam int RAMW  = C_S_RAM_DEPTH_LOG2;
`ifdef AXI_SLV_DECERR_EN
    // Full-width word index so beats past the top are detectable.
    localparam int IDXW  = C_S_AXI_ADDR_WIDTH - SHIFT;
`else
    localparam int IDXW  = RAMW;
`endif
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int IW    = C_S_AXI_ID_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic [IDXW-1:0] f_idx(
        input logic [C_S_AXI_ADDR_WIDTH-1:0] a
    );
        logic [C_S_AXI_ADDR_WIDTH-1:0] d;
        d = a - C_S_BASE_ADDR;
        return IDXW'(d >> SHIFT);
    endfunction

    logic              r_up;
    logic [DW-1:0]     r_mem [0:(1<<RAMW)-1];
    logic [DW-1:0]     r_ram_q;

    w_state_t          r_wst, w_wst_nxt;
    logic [IW-1:0]     r_wid;
    logic [IDXW-1:0]   r_widx;
    logic [7:0]        r_wlen, r_wcnt;
    logic              r_wfixed, r_werr, r_wdec;
    logic              w_aw_hs, w_w_hs, w_win, w_ram_we;

    r_state_t          r_rst, w_rst_nxt;
    logic [IW-1:0]     r_rid;
    logic [IDXW-1:0]   r_ridx;
    logic [7:0]        r_rlen, r_rcnt;
    logic              r_rfixed, r_rerr, r_riss_done;
    logic              r_p1_v, r_p1_last, r_p1_dec;
    logic              r_rvalid, r_rlast;
    logic [DW-1:0]     r_rdata;
    logic [1:0]        r_rresp;
    logic              w_ar_hs, w_rin, w_out_load, w_ram_re;

    // Ready signals stay low until the first edge after reset release.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) r_up <= 1'b0;
        else              r_up <= 1'b1;
    end

`ifdef AXI_SLV_DECERR_EN
    assign w_win = ((r_widx >> RAMW) == '0);
    assign w_rin = ((r_ridx >> RAMW) == '0);
`else
    assign w_win = 1'b1;
    assign w_rin = 1'b1;
`endif

    // ---------------- write path ----------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) r_wst <= W_IDLE;
        else              r_wst <= w_wst_nxt;
    end

    always_comb begin
        w_wst_nxt           = r_wst;
        s_axi.S_AXI_AWREADY = 1'b0;
        s_axi.S_AXI_WREADY  = 1'b0;
        s_axi.S_AXI_BVALID  = 1'b0;
        unique case (r_wst)
            W_IDLE: begin
                s_axi.S_AXI_AWREADY = r_up;
                if (r_up && s_axi.S_AXI_AWVALID) w_wst_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi.S_AXI_WREADY = 1'b1;
                if (s_axi.S_AXI_WVALID && r_wcnt == r_wlen)
                    w_wst_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi.S_AXI_BVALID = 1'b1;
                if (s_axi.S_AXI_BREADY) w_wst_nxt = W_IDLE;
            end
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    assign w_aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    assign w_ram_we = w_w_hs && w_win;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wid    <= '0;
            r_widx   <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wfixed <= 1'b0;
            r_werr   <= 1'b0;
            r_wdec   <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_wid    <= s_axi.S_AXI_AWID;
                r_widx   <= f_idx(s_axi.S_AXI_AWADDR);
                r_wlen   <= s_axi.S_AXI_AWLEN;
                r_wcnt   <= '0;
                r_wfixed <= (s_axi.S_AXI_AWBURST == 2'b00);
                r_werr   <= (s_axi.S_AXI_AWBURST == 2'b10) ||
                            (s_axi.S_AXI_AWSIZE != 3'(SHIFT));
                r_wdec   <= 1'b0;
            end
            if (w_w_hs) begin
                r_wcnt <= r_wcnt + 8'd1;
                if (!r_wfixed) r_widx <= r_widx + 1'b1;
                // Burst length comes from AWLEN; WLAST is only checked.
                if (s_axi.S_AXI_WLAST != (r_wcnt == r_wlen))
                    r_werr <= 1'b1;
                if (!w_win) r_wdec <= 1'b1;
            end
        end
    end

    assign s_axi.S_AXI_BID   = r_wid;
    assign s_axi.S_AXI_BRESP = r_wdec ? 2'b11 : {r_werr, 1'b0};

    // ---------------- RAM (read-first) ----------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_ram_we) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi.S_AXI_WSTRB[b])
                    r_mem[r_widx[RAMW-1:0]][8*b +: 8] <=
                        s_axi.S_AXI_WDATA[8*b +: 8];
            end
        end
        if (w_ram_re) r_ram_q <= r_mem[r_ridx[RAMW-1:0]];
    end

    // ---------------- read path ----------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) r_rst <= R_IDLE;
        else              r_rst <= w_rst_nxt;
    end

    always_comb begin
        w_rst_nxt           = r_rst;
        s_axi.S_AXI_ARREADY = 1'b0;
        unique case (r_rst)
            R_IDLE: begin
                s_axi.S_AXI_ARREADY = r_up;
                if (r_up && s_axi.S_AXI_ARVALID) w_rst_nxt = R_DATA;
            end
            R_DATA: begin
                if (r_rvalid && r_rlast && s_axi.S_AXI_RREADY)
                    w_rst_nxt = R_IDLE;
            end
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    assign w_ar_hs    = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    // Output register takes a new beat when empty or being drained.
    assign w_out_load = !r_rvalid || s_axi.S_AXI_RREADY;
    // RAM stage issues only if its result has somewhere to go; while
    // stalled r_ram_q keeps the prefetched beat.
    assign w_ram_re   = (r_rst == R_DATA) && !r_riss_done &&
                        (!r_p1_v || w_out_load);

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rid       <= '0;
            r_ridx      <= '0;
            r_rlen      <= '0;
            r_rcnt      <= '0;
            r_rfixed    <= 1'b0;
            r_rerr      <= 1'b0;
            r_riss_done <= 1'b0;
            r_p1_v      <= 1'b0;
            r_p1_last   <= 1'b0;
            r_p1_dec    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rid       <= s_axi.S_AXI_ARID;
                r_ridx      <= f_idx(s_axi.S_AXI_ARADDR);
                r_rlen      <= s_axi.S_AXI_ARLEN;
                r_rcnt      <= '0;
                r_rfixed    <= (s_axi.S_AXI_ARBURST == 2'b00);
                r_rerr      <= (s_axi.S_AXI_ARBURST == 2'b10) ||
                               (s_axi.S_AXI_ARSIZE != 3'(SHIFT));
                r_riss_done <= 1'b0;
            end
            if (w_ram_re) begin
                r_p1_last <= (r_rcnt == r_rlen);
                r_p1_dec  <= !w_rin;
                if (r_rcnt == r_rlen) r_riss_done <= 1'b1;
                else                  r_rcnt <= r_rcnt + 8'd1;
                if (!r_rfixed) r_ridx <= r_ridx + 1'b1;
            end
            if (w_ram_re)        r_p1_v <= 1'b1;
            else if (w_out_load) r_p1_v <= 1'b0;
            if (w_out_load) begin
                r_rvalid <= r_p1_v;
                r_rlast  <= r_p1_v && r_p1_last;
                r_rdata  <= (r_p1_v && !r_p1_dec) ? r_ram_q : '0;
                r_rresp  <= !r_p1_v  ? 2'b00 :
                            r_p1_dec ? 2'b11 : {r_rerr, 1'b0};
            end
        end
    end

    assign s_axi.S_AXI_RID    = r_rid;
    assign s_axi.S_AXI_RDATA  = r_rdata;
    assign s_axi.S_AXI_RRESP  = r_rresp;
    assign s_axi.S_AXI_RLAST  = r_rlast;
    assign s_axi.S_AXI_RVALID = r_rvalid;
endmodule
